// File: rtl/pe_lane_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pe_lane_array
// Brief    : LANES-wide Q8.8 processing element (MAC-ext, EWM, EWA, MAC-int)
//            with a two-stage valid/ready pipeline. Optional macro PE_SAT_EN
//            enables saturating stage-2 adds and per-lane sat_flag.
// Revision : 1.0 - initial release
// ============================================================================
module pe_lane_array #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    mode,
    input  logic                          acc_first,
    input  logic                          acc_last,
    input  logic [LANES*DATA_WIDTH-1:0]   a_in,
    input  logic [LANES*DATA_WIDTH-1:0]   b_in,
    input  logic [LANES*ACC_WIDTH-1:0]    acc_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    result_out,
    output logic [LANES-1:0]              sat_flag
);

    localparam logic [1:0] c_mode_mac_ext = 2'b00;
    localparam logic [1:0] c_mode_ewm     = 2'b01;
    localparam logic [1:0] c_mode_ewa     = 2'b10;
    localparam logic [1:0] c_mode_mac_int = 2'b11;

    logic       s1_valid_q;
    logic [1:0] mode_q;
    logic       first_q;
    logic       last_q;
    logic       out_valid_q;

    logic w_stall;
    logic w_fire;
    logic w_emit;

    assign w_stall   = out_valid_q && !out_ready;
    assign in_ready  = !w_stall;
    assign w_fire    = in_valid && in_ready;
    // Internal-accumulate beats only surface a result on the closing beat.
    assign w_emit    = (mode_q != c_mode_mac_int) || last_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            mode_q      <= c_mode_mac_ext;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!w_stall) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q && w_emit;
            if (w_fire) begin
                mode_q  <= mode;
                first_q <= acc_first;
                last_q  <= acc_last;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   w_a;
        logic signed [DATA_WIDTH-1:0]   w_b;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic signed [DATA_WIDTH:0]     w_sum;
        logic signed [ACC_WIDTH-1:0]    w_sum_ext;

        logic signed [ACC_WIDTH-1:0] prod_q;
        logic signed [ACC_WIDTH-1:0] sum_q;
        logic signed [ACC_WIDTH-1:0] acc_in_q;
        logic signed [ACC_WIDTH-1:0] acc_q;
        logic        [ACC_WIDTH-1:0] res_q;
        logic                        sat_q;
        logic                        sticky_q;

        logic signed [ACC_WIDTH-1:0] w_addend;
        logic signed [ACC_WIDTH-1:0] w_add_res;
        logic                        w_sat_hit;
        logic                        w_sticky_d;
        logic        [ACC_WIDTH-1:0] w_res_d;
        logic                        w_sat_d;

        assign w_a       = a_in[l*DATA_WIDTH +: DATA_WIDTH];
        assign w_b       = b_in[l*DATA_WIDTH +: DATA_WIDTH];
        assign w_prod    = (2*DATA_WIDTH)'(w_a) * (2*DATA_WIDTH)'(w_b);
        assign w_sum     = (DATA_WIDTH+1)'(w_a) + (DATA_WIDTH+1)'(w_b);
        assign w_sum_ext = ACC_WIDTH'(w_sum) <<< FRAC_BITS;

        assign w_addend  = (mode_q == c_mode_mac_int) ? (first_q ? '0 : acc_q) : acc_in_q;

`ifdef PE_SAT_EN
        logic signed [ACC_WIDTH:0] w_wide;
        logic                      w_ovf;

        // One extra bit exposes signed overflow as a disagreement of the top two bits.
        assign w_wide    = (ACC_WIDTH+1)'(prod_q) + (ACC_WIDTH+1)'(w_addend);
        assign w_ovf     = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
        assign w_add_res = !w_ovf ? w_wide[ACC_WIDTH-1:0] :
                           (w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                              : {1'b0, {(ACC_WIDTH-1){1'b1}}});
        assign w_sat_hit = w_ovf;
`else
        assign w_add_res = prod_q + w_addend;
        assign w_sat_hit = 1'b0;
`endif

        assign w_sticky_d = (first_q ? 1'b0 : sticky_q) | w_sat_hit;

        always_comb begin
            w_res_d = w_add_res;
            w_sat_d = 1'b0;
            case (mode_q)
                c_mode_mac_ext: w_sat_d = w_sat_hit;
                c_mode_ewm:     w_res_d = prod_q;
                c_mode_ewa:     w_res_d = sum_q;
                default:        w_sat_d = w_sticky_d;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_q   <= '0;
                sum_q    <= '0;
                acc_in_q <= '0;
                acc_q    <= '0;
                res_q    <= '0;
                sat_q    <= 1'b0;
                sticky_q <= 1'b0;
            end else if (!w_stall) begin
                if (w_fire) begin
                    prod_q   <= ACC_WIDTH'(w_prod);
                    sum_q    <= w_sum_ext;
                    acc_in_q <= acc_in[l*ACC_WIDTH +: ACC_WIDTH];
                end
                if (s1_valid_q) begin
                    if (mode_q == c_mode_mac_int) begin
                        acc_q    <= w_add_res;
                        sticky_q <= w_sticky_d;
                    end
                    if (w_emit) begin
                        res_q <= w_res_d;
                        sat_q <= w_sat_d;
                    end
                end
            end
        end

        assign result_out[l*ACC_WIDTH +: ACC_WIDTH] = res_q;
        assign sat_flag[l]                          = sat_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_lane_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pe_lane_array
// Brief    : Self-checking scoreboard bench for pe_lane_array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_lane_array;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            mode;
    logic                  acc_first;
    logic                  acc_last;
    logic [LANES*DW-1:0]   a_in;
    logic [LANES*DW-1:0]   b_in;
    logic [LANES*AW-1:0]   acc_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*AW-1:0]   result_out;
    logic [LANES-1:0]      sat_flag;

    pe_lane_array #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .acc_first  (acc_first),
        .acc_last   (acc_last),
        .a_in       (a_in),
        .b_in       (b_in),
        .acc_in     (acc_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*AW-1:0] res;
        logic [LANES-1:0]    sat;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_out    = 0;
    longint m_acc[LANES];
    bit     m_sticky[LANES];
    bit     stall_prev = 1'b0;
    logic [LANES*AW-1:0] held_res;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of one accepted beat; pushes the expected output if one is due.
    task automatic model_beat(input logic [1:0] md, input logic f, input logic l,
                              input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                              input logic [LANES*AW-1:0] ai);
        exp_t e;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            longint av, bv, t;
            logic [63:0] tv;
            bit s;
            av = longint'($signed(a[i*DW +: DW]));
            bv = longint'($signed(b[i*DW +: DW]));
            s  = 1'b0;
            case (md)
                2'b00:   t = av * bv + longint'($signed(ai[i*AW +: AW]));
                2'b01:   t = av * bv;
                2'b10:   t = (av + bv) * 256;
                default: t = (f ? 64'sd0 : m_acc[i]) + av * bv;
            endcase
`ifdef PE_SAT_EN
            if (md == 2'b00 || md == 2'b11) begin
                if (t > 64'sd2147483647) begin
                    t = 64'sd2147483647;
                    s = 1'b1;
                end else if (t < -64'sd2147483648) begin
                    t = -64'sd2147483648;
                    s = 1'b1;
                end
            end
`endif
            tv = t;
            if (md == 2'b11) begin
                m_acc[i]    = longint'($signed(tv[31:0]));
                m_sticky[i] = (f ? 1'b0 : m_sticky[i]) | s;
                s           = m_sticky[i];
            end
            e.res[i*AW +: AW] = tv[31:0];
            e.sat[i]          = s;
        end
        if (md != 2'b11 || l) sb_q.push_back(e);
    endtask

    task automatic send(input logic [1:0] md, input logic f, input logic l,
                        input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                        input logic [LANES*AW-1:0] ai);
        int guard;
        bit acc;
        guard     = 0;
        in_valid  = 1'b1;
        mode      = md;
        acc_first = f;
        acc_last  = l;
        a_in      = a;
        b_in      = b;
        acc_in    = ai;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("send_accept", acc, 1);
        else model_beat(md, f, l, a, b, ai);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard    = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    function automatic logic [LANES*DW-1:0] rep16(input logic [DW-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [LANES*AW-1:0] rep32(input logic [AW-1:0] v);
        return {LANES{v}};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_result", result_out, held_res);
                check("hold_valid", out_valid, 1);
            end
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", result_out, e.res);
                    check("sat_flag", sat_flag, e.sat);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_res   = result_out;
        end
    end

    bit rnd_done;

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'b00;
        acc_first = 1'b0;
        acc_last  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        acc_in    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            m_acc[i]    = 0;
            m_sticky[i] = 1'b0;
        end
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result_out, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // EWM with latency check
        send(2'b01, 0, 0, rep16(16'h0180), rep16(16'h0200), '0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat1_valid", out_valid, 0);
        @(negedge clk);
        check("lat2_valid", out_valid, 1);
        check("ewm_value", result_out, rep32(32'h0003_0000));
        drain();

        // EWA, including the most-negative operand pair
        send(2'b10, 0, 0, rep16(16'h0180), rep16(16'h0200), '0);
        send(2'b10, 0, 0, rep16(16'h8000), rep16(16'h8000), '0);
        // MAC-ext
        send(2'b00, 0, 0, rep16(16'h0100), rep16(16'hFF00), rep32(32'h0005_0000));
        drain();

        // MAC-int: 4-beat reduction, then an independent single-beat one
        base = n_out;
        send(2'b11, 1, 0, rep16(16'h0200), rep16(16'h0300), '0);
        send(2'b11, 0, 0, rep16(16'h0200), rep16(16'h0300), '0);
        send(2'b11, 0, 0, rep16(16'h0200), rep16(16'h0300), '0);
        send(2'b11, 0, 1, rep16(16'h0200), rep16(16'h0300), '0);
        send(2'b11, 1, 1, rep16(16'h0100), rep16(16'h0100), '0);
        drain();
        check("macint_outputs", n_out - base, 2);

        // Mode change mid-reduction leaves the accumulator alone
        send(2'b11, 1, 0, {16'h0100, 16'h0200, 16'hFF00, 16'h0080}, rep16(16'h0400), '0);
        send(2'b10, 0, 0, rep16(16'h1234), rep16(16'h0101), '0);
        send(2'b11, 0, 1, {16'h0300, 16'hFE00, 16'h0100, 16'h0040}, rep16(16'h0200), '0);
        drain();

        // Backpressure: 8 EWM beats, out_ready low for cycles 3..6
        base = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(2'b01, 0, 0, rep16(16'(16'h0100 + k * 16)), {16'h0100, 16'h0200, 16'h0300, 16'hFF00}, '0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - base, 8);

        // Large-operand reduction: saturates or wraps depending on build
        send(2'b11, 1, 0, rep16(16'h7FFF), rep16(16'h7FFF), '0);
        send(2'b11, 0, 0, rep16(16'h7FFF), rep16(16'h7FFF), '0);
        send(2'b11, 0, 1, rep16(16'h7FFF), rep16(16'h7FFF), '0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifdef PE_SAT_EN
        check("sat_value", result_out, rep32(32'h7FFF_FFFF));
        check("sat_flag_set", sat_flag, 4'hF);
`else
        check("wrap_value", result_out, rep32(32'hBFFD_0003));
        check("wrap_flag", sat_flag, 4'h0);
`endif
        drain();

        // Reset in the middle of a reduction
        base = n_out;
        send(2'b11, 1, 0, rep16(16'h0500), rep16(16'h0500), '0);
        send(2'b11, 0, 0, rep16(16'h0500), rep16(16'h0500), '0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_sb", sb_q.size(), 0);
        sb_q.delete();
        for (int i = 0; i < LANES; i++) begin
            m_acc[i]    = 0;
            m_sticky[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_no_out", n_out - base, 0);
        send(2'b11, 0, 1, rep16(16'h0200), rep16(16'h0300), '0);
        drain();
        check("postrst_outputs", n_out - base, 1);

        // Random mixed traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++)
                    send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         {$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom, $urandom, $urandom});
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
